// File: rtl/life_ctrl_pkg.sv
// Sequencer state encoding for the Life array controller.
package life_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STEP   = 3'd2,
    SETTLE = 3'd3,
    READ   = 3'd4
  } life_state_e;
endpackage

// File: rtl/pe_cmd_pkg.sv
// Command encodings and cell width shared by the Life PE array and every block that drives it.
package pe_cmd_pkg;
  localparam int PE_CMD_BITS   = 2;
  localparam int PE_STATE_BITS = 1;

  localparam logic [PE_CMD_BITS-1:0] PE_CMD_NOP   = 2'd0;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_WRITE = 2'd1;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_STEP  = 2'd2;
endpackage

// File: rtl/life_skid_buf.sv
// Two-entry valid/ready buffer between the array read port and the readout stream.
module life_skid_buf #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         has_space,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  // Space is judged without crediting a same-cycle pop, so the FSM never depends on rd_ready combinationally.
  assign has_space = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign do_push   = push && has_space;
  assign do_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/life_seq_ctrl.sv
// Load / run / readout sequencer that is the sole master of the Life PE array interface.
// Handshakes: a transfer happens on a cycle where valid && ready; valid never waits on ready.
module life_seq_ctrl
  import pe_cmd_pkg::*;
  import life_ctrl_pkg::*;
#(
  parameter int N_PX      = 16,
  parameter int N_PY      = 16,
  parameter int GEN_BITS  = 16,
  localparam int N_PX_BITS = (N_PX > 1) ? $clog2(N_PX) : 1,
  localparam int N_PY_BITS = (N_PY > 1) ? $clog2(N_PY) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [GEN_BITS-1:0]      gens,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [PE_STATE_BITS-1:0] ld_cell,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [PE_STATE_BITS-1:0] rd_cell,
  output logic                     busy,
  output logic                     extinct,
  output logic [GEN_BITS-1:0]      gens_done,
  output logic [PE_CMD_BITS-1:0]   pe_cmd,
  output logic [PE_STATE_BITS-1:0] pe_state_in,
  output logic [N_PX_BITS-1:0]     pe_adr_x_i,
  output logic [N_PY_BITS-1:0]     pe_adr_y_i,
  output logic [N_PX_BITS-1:0]     pe_adr_x_o,
  output logic [N_PY_BITS-1:0]     pe_adr_y_o,
  input  logic [PE_STATE_BITS-1:0] pe_state_out,
  input  logic                     pe_active,
  output life_state_e              fsm_state
);
  localparam logic [N_PX_BITS-1:0] X_LAST = N_PX_BITS'(N_PX - 1);
  localparam logic [N_PY_BITS-1:0] Y_LAST = N_PY_BITS'(N_PY - 1);

  life_state_e           state_q;
  life_state_e           state_d;
  logic [N_PX_BITS-1:0]  x_q;
  logic [N_PY_BITS-1:0]  y_q;
  logic [GEN_BITS-1:0]   gens_q;
  logic [GEN_BITS-1:0]   gens_done_q;
  logic                  extinct_q;
  logic                  rd_issued_q;
  logic                  raster_last;
  logic                  start_ok;
  logic                  ld_fire;
  logic                  rd_push;
  logic                  buf_space;
  logic                  buf_valid;
  logic                  buf_pop_en;

  assign raster_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign start_ok    = (state_q == IDLE) && start;
  assign ld_fire     = (state_q == LOAD) && ld_valid;
  assign rd_push     = (state_q == READ) && !rd_issued_q && buf_space;
  assign buf_pop_en  = (state_q == READ) && rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_ready    = 1'b0;
    pe_cmd      = PE_CMD_NOP;
    pe_state_in = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          pe_cmd      = PE_CMD_WRITE;
          pe_state_in = ld_cell;
          if (raster_last) state_d = (gens_q == '0) ? READ : STEP;
        end
      end
      STEP: begin
        pe_cmd  = PE_CMD_STEP;
        state_d = SETTLE;
      end
      SETTLE: begin
        // Extinction wins over the generation count so extinct is reported even on the final generation.
        if (!pe_active)                 state_d = READ;
        else if (gens_done_q == gens_q) state_d = READ;
        else                            state_d = STEP;
      end
      READ: begin
        if (rd_issued_q && !buf_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One raster counter serves both the write address during LOAD and the read address during READ.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      x_q <= '0;
      y_q <= '0;
    end else if (ld_fire || rd_push) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gens_q      <= '0;
      gens_done_q <= '0;
      extinct_q   <= 1'b0;
      rd_issued_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            gens_q      <= gens;
            gens_done_q <= '0;
            extinct_q   <= 1'b0;
            rd_issued_q <= 1'b0;
          end
        end
        STEP: begin
          if (gens_done_q != '1) gens_done_q <= gens_done_q + 1'b1;
        end
        SETTLE: begin
          if (!pe_active) extinct_q <= 1'b1;
        end
        READ: begin
          if (rd_push && raster_last) rd_issued_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  life_skid_buf #(
    .W(PE_STATE_BITS)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_push),
    .push_data (pe_state_out),
    .has_space (buf_space),
    .out_valid (buf_valid),
    .out_ready (buf_pop_en),
    .out_data  (rd_cell)
  );

  assign rd_valid   = buf_valid;
  assign busy       = (state_q != IDLE);
  assign extinct    = extinct_q;
  assign gens_done  = gens_done_q;
  assign pe_adr_x_i = x_q;
  assign pe_adr_y_i = y_q;
  assign pe_adr_x_o = x_q;
  assign pe_adr_y_o = y_q;
  assign fsm_state  = state_q;
endmodule

// File: tb/tb_life_seq_ctrl.sv
// Directed bench for life_seq_ctrl driving a behavioural 4x4 Life array (dead cells outside the board).
module tb_life_seq_ctrl;
  import pe_cmd_pkg::*;
  import life_ctrl_pkg::*;

  localparam int GB = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic [GB-1:0]            gens = '0;
  logic                     ld_valid = 1'b0;
  logic                     ld_ready;
  logic [PE_STATE_BITS-1:0] ld_cell = '0;
  logic                     rd_valid;
  logic                     rd_ready = 1'b0;
  logic [PE_STATE_BITS-1:0] rd_cell;
  logic                     busy;
  logic                     extinct;
  logic [GB-1:0]            gens_done;
  logic [PE_CMD_BITS-1:0]   pe_cmd;
  logic [PE_STATE_BITS-1:0] pe_state_in;
  logic [1:0]               pe_adr_x_i, pe_adr_y_i, pe_adr_x_o, pe_adr_y_o;
  logic [PE_STATE_BITS-1:0] pe_state_out;
  logic                     pe_active;
  life_state_e              fsm_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int step_total = 0;
  int step_prev_cyc = 0;
  int step_last_cyc = 0;
  logic [15:0] board = '0;

  life_seq_ctrl #(.N_PX(4), .N_PY(4), .GEN_BITS(GB)) dut (
    .clk(clk), .reset(reset), .start(start), .gens(gens),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_cell(ld_cell),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cell(rd_cell),
    .busy(busy), .extinct(extinct), .gens_done(gens_done),
    .pe_cmd(pe_cmd), .pe_state_in(pe_state_in),
    .pe_adr_x_i(pe_adr_x_i), .pe_adr_y_i(pe_adr_y_i),
    .pe_adr_x_o(pe_adr_x_o), .pe_adr_y_o(pe_adr_y_o),
    .pe_state_out(pe_state_out), .pe_active(pe_active), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] life_next(input logic [15:0] b);
    logic [15:0] n;
    int cnt;
    n = '0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 4 && y + dy >= 0 && y + dy < 4)
              cnt += int'(b[(y + dy) * 4 + x + dx]);
        n[y * 4 + x] = (cnt == 3) || (cnt == 2 && b[y * 4 + x]);
      end
    end
    return n;
  endfunction

  // Behavioural PE array plus a monitor of STEP commands.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pe_cmd == PE_CMD_WRITE) board[{pe_adr_y_i, pe_adr_x_i}] <= pe_state_in[0];
    else if (pe_cmd == PE_CMD_STEP) board <= life_next(board);
    if (pe_cmd == PE_CMD_STEP) begin
      step_total    <= step_total + 1;
      step_prev_cyc <= step_last_cyc;
      step_last_cyc <= cyc;
    end
  end
  assign pe_state_out = board[{pe_adr_y_o, pe_adr_x_o}];
  assign pe_active    = |board;

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [GB-1:0] g);
    @(negedge clk);
    start = 1'b1;
    gens  = g;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_board(input logic [15:0] pat, input bit gaps, output bit to);
    int idx = 0;
    int guard = 0;
    to = 1'b0;
    while (idx < 16 && guard < 500) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_cell  = pat[idx];
        #1;
        if (ld_ready) idx++;
      end
      guard++;
    end
    if (idx < 16) to = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic read_board(input bit bp, output logic [15:0] got, output int n,
                            output int extra, output bit to);
    int c = 0;
    got = '0; n = 0; extra = 0; to = 1'b0;
    while (n < 16 && c < 400) begin
      @(negedge clk);
      if (bp) rd_ready = (c >= 4 && c < 24) ? 1'b0 : 1'($urandom_range(0, 1));
      else    rd_ready = 1'b1;
      #1;
      if (rd_valid && rd_ready) begin
        got[n] = rd_cell[0];
        n++;
      end
      c++;
    end
    if (n < 16) to = 1'b1;
    rd_ready = 1'b1;
    c = 0;
    while (busy && c < 10) begin
      @(negedge clk);
      #1;
      if (rd_valid) extra++;
      c++;
    end
    if (busy) to = 1'b1;
    rd_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ld_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({busy, ld_ready, rd_valid, extinct} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags busy/ld_ready/rd_valid/extinct=%b expected 0000", {busy, ld_ready, rd_valid, extinct});
    end
    tests_run++;
    if (pe_cmd !== PE_CMD_NOP || gens_done !== '0 || {pe_adr_x_i, pe_adr_y_i} !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_regs cmd=%0d gens_done=%0d adr=%h expected 0/0/0", pe_cmd, gens_done, {pe_adr_x_i, pe_adr_y_i});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (pe_cmd !== PE_CMD_NOP || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ignores_ld_valid cmd=%0d busy=%b expected NOP/0", pe_cmd, busy);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_blinker_gen1();
    logic [15:0] got; int n, extra; bit to1, to2;
    do_start(16'd1);
    load_board(16'h0222, 1'b0, to1);
    read_board(1'b0, got, n, extra, to2);
    tests_run++;
    if (to1 || to2 || n != 16 || got !== 16'h0070) begin
      tests_failed++;
      $display("FAIL blinker_gen1 board=%h n=%0d to=%b%b expected 0070 n=16", got, n, to1, to2);
    end
    tests_run++;
    if (extinct !== 1'b0 || gens_done !== 16'd1) begin
      tests_failed++;
      $display("FAIL blinker_gen1_status extinct=%b gens_done=%0d expected 0/1", extinct, gens_done);
    end
  endtask

  task automatic test_blinker_gen2();
    logic [15:0] got; int n, extra; bit to1, to2; int s0;
    s0 = step_total;
    do_start(16'd2);
    load_board(16'h0222, 1'b0, to1);
    read_board(1'b0, got, n, extra, to2);
    tests_run++;
    if (to1 || to2 || got !== 16'h0222 || gens_done !== 16'd2) begin
      tests_failed++;
      $display("FAIL blinker_gen2 board=%h gens_done=%0d expected 0222/2", got, gens_done);
    end
    tests_run++;
    if (step_total - s0 != 2 || step_last_cyc - step_prev_cyc != 2) begin
      tests_failed++;
      $display("FAIL step_spacing steps=%0d gap=%0d expected 2/2", step_total - s0, step_last_cyc - step_prev_cyc);
    end
  endtask

  task automatic test_extinct();
    logic [15:0] got; int n, extra; bit to1, to2; int s0;
    s0 = step_total;
    do_start(16'd10);
    load_board(16'h0400, 1'b0, to1);
    read_board(1'b0, got, n, extra, to2);
    tests_run++;
    if (to1 || to2 || got !== 16'h0000) begin
      tests_failed++;
      $display("FAIL extinct_board board=%h expected 0000", got);
    end
    tests_run++;
    if (extinct !== 1'b1 || gens_done !== 16'd1 || step_total - s0 != 1) begin
      tests_failed++;
      $display("FAIL extinct_status extinct=%b gens_done=%0d steps=%0d expected 1/1/1",
               extinct, gens_done, step_total - s0);
    end
  endtask

  task automatic test_gens_zero(input bit gaps, input logic [15:0] pat);
    logic [15:0] got; int n, extra; bit to1, to2; int s0;
    s0 = step_total;
    rd_ready = 1'b0;
    do_start(16'd0);
    load_board(pat, gaps, to1);
    #1;
    tests_run++;
    if (fsm_state !== READ || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_entry state=%0d rd_valid=%b expected READ/0", fsm_state, rd_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_cell[0] !== pat[0]) begin
      tests_failed++;
      $display("FAIL first_cell_latency rd_valid=%b cell=%b expected 1/%b", rd_valid, rd_cell, pat[0]);
    end
    read_board(1'b0, got, n, extra, to2);
    tests_run++;
    if (to1 || to2 || got !== pat || step_total != s0 || gens_done !== '0) begin
      tests_failed++;
      $display("FAIL gens_zero gaps=%b board=%h steps=%0d expected %h/0", gaps, got, step_total - s0, pat);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got; int n, extra; bit to1, to2;
    do_start(16'd0);
    load_board(16'h1E69, 1'b0, to1);
    read_board(1'b1, got, n, extra, to2);
    tests_run++;
    if (to1 || to2 || n != 16 || extra != 0 || got !== 16'h1E69) begin
      tests_failed++;
      $display("FAIL backpressure board=%h n=%0d extra=%0d expected 1e69/16/0", got, n, extra);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] got; int n, extra, c; bit to1, to2;
    do_start(16'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_cell  = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || pe_cmd !== PE_CMD_NOP || ld_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_load busy=%b rd_valid=%b cmd=%0d ld_ready=%b expected 0/0/NOP/0",
               busy, rd_valid, pe_cmd, ld_ready);
    end
    reset = 1'b0;
    ld_valid = 1'b0;
    rd_ready = 1'b0;
    do_start(16'd0);
    load_board(16'hFFFF, 1'b0, to1);
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (rd_valid !== 1'b1 || fsm_state !== READ) begin
      tests_failed++;
      $display("FAIL read_stall rd_valid=%b state=%0d expected 1/READ", rd_valid, fsm_state);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || pe_cmd !== PE_CMD_NOP) begin
      tests_failed++;
      $display("FAIL reset_mid_read busy=%b rd_valid=%b cmd=%0d expected 0/0/NOP", busy, rd_valid, pe_cmd);
    end
    reset = 1'b0;
    do_start(16'd5);
    load_board(16'h0222, 1'b0, to1);
    c = 0;
    #1;
    while (fsm_state != STEP && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    start = 1'b1;
    gens  = 16'd0;
    @(negedge clk);
    start = 1'b0;
    #1;
    tests_run++;
    if (fsm_state !== SETTLE) begin
      tests_failed++;
      $display("FAIL start_in_step state=%0d expected SETTLE", fsm_state);
    end
    read_board(1'b0, got, n, extra, to2);
    tests_run++;
    if (to1 || to2 || got !== 16'h0070 || gens_done !== 16'd5) begin
      tests_failed++;
      $display("FAIL start_ignored_run board=%h gens_done=%0d expected 0070/5", got, gens_done);
    end
  endtask

  initial begin
    test_reset();
    test_blinker_gen1();
    test_blinker_gen2();
    test_extinct();
    test_gens_zero(1'b0, 16'hA5C3);
    test_gens_zero(1'b1, 16'h3C96);
    test_backpressure();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
